// File: rtl/usb_fifo_writer.sv
`timescale 1ns/1ps
// usb_fifo_writer
//   Moves one block of BLOCK_BYTES bytes from the ping-pong sample buffer
//   into the FX2 slave FIFO each time the buffer mux raises send_go.
//   Reads are issued against a credit limit so that every byte returned
//   by the buffer has a guaranteed slot in the skid FIFO, which lets the
//   FX2 full flag stall writes without losing or repeating data.
//
// Ports
//   usbdataclk  in   FX2 IFCLK, the only clock
//   rst_n       in   asynchronous active-low reset
//   send_go     in   buffer-ready level; a rising edge starts one block
//   usbdata     in   buffer read data, valid RD_LAT cycles after usbdadd
//   usbdadd     out  buffer read address
//   fx2_full_n  in   FX2 FIFO full flag (active-low)
//   fx2_fd      out  FX2 data bus
//   fx2_slwr_n  out  FX2 write strobe (active-low)
//   fx2_fifoadr out  FX2 endpoint select (constant EP_ADDR)
//   busy        out  transfer in progress
//   xfer_done   out  one-cycle pulse after the last byte is written
//   overrun     out  sticky: a block arrived while a transfer was running
//
// state   | meaning
// S_IDLE  | waiting for a send_go rising edge
// S_RUN   | issuing buffer reads and writing to the FX2
// S_DRAIN | all reads issued, writing the remaining bytes
// S_DONE  | one cycle, xfer_done asserted
module usb_fifo_writer #(
  parameter int         BLOCK_BYTES = 2048,
  parameter int         ADDR_W      = 11,
  parameter int         RD_LAT      = 2,
  parameter int         SKID_DEPTH  = 4,
  parameter logic [1:0] EP_ADDR     = 2'b10
) (
  input  logic              usbdataclk,
  input  logic              rst_n,
  input  logic              send_go,
  input  logic [7:0]        usbdata,
  output logic [ADDR_W-1:0] usbdadd,
  input  logic              fx2_full_n,
  output logic [7:0]        fx2_fd,
  output logic              fx2_slwr_n,
  output logic [1:0]        fx2_fifoadr,
  output logic              busy,
  output logic              xfer_done,
  output logic              overrun
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + RD_LAT + 4);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_BYTES - 1);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(BLOCK_BYTES - 2);
  localparam logic [ADDR_W:0]   BLOCK_CNT = (ADDR_W+1)'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(SKID_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(SKID_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_send_go_d;
  logic               w_start;
  logic [ADDR_W-1:0]  r_addr;
  logic [RD_LAT-1:0]  r_vld;
  logic [7:0]         r_skid [SKID_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_skid_cnt;
  logic [ADDR_W:0]    r_wr_cnt;
  logic               r_ovr;
  logic               r_slwr_n;
  logic [7:0]         r_fd;
  logic [CNT_W-1:0]   w_outst;
  logic [CNT_W-1:0]   w_credit_used;
  logic               w_pre_last_ok;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;

  assign w_start = send_go & ~r_send_go_d;

  always_comb begin
    w_outst = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_outst = w_outst + CNT_W'(r_vld[i]);
    end
  end

  assign w_credit_used = w_outst + r_skid_cnt;
  assign w_pop         = fx2_full_n && (r_skid_cnt != '0);
  assign w_push        = r_vld[RD_LAT-1];

  // The mux flips banks when it sees the last address, so that address must
  // be on the bus for exactly one cycle. Only step onto it when the credit
  // for issuing it next cycle is already certain: pushes do not change the
  // credit total, so next cycle's total is used + 1 - pop.
  assign w_pre_last_ok = (w_credit_used + CNT_W'(2)) <= (DEPTH_C + CNT_W'(w_pop));

  assign w_issue = (r_state == S_RUN) && (w_credit_used < DEPTH_C) &&
                   ((r_addr != PRE_LAST) || w_pre_last_ok);

  always_ff @(posedge usbdataclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    xfer_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_issue && (r_addr == LAST_ADDR)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_wr_cnt == BLOCK_CNT) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        xfer_done   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge usbdataclk or negedge rst_n) begin
    if (!rst_n) begin
      r_send_go_d <= 1'b0;
      r_addr      <= '0;
      r_vld       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_skid_cnt  <= '0;
      r_wr_cnt    <= '0;
      r_ovr       <= 1'b0;
      r_slwr_n    <= 1'b1;
      r_fd        <= '0;
    end else begin
      r_send_go_d <= send_go;

      if (w_start && (r_state != S_IDLE)) r_ovr <= 1'b1;

      if (w_issue) r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;

      r_vld[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end

      if (w_push) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;

      r_slwr_n <= ~w_pop;
      if (w_pop) begin
        r_rptr   <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
        r_fd     <= r_skid[r_rptr];
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_skid_cnt <= r_skid_cnt + 1'b1;
        2'b01:   r_skid_cnt <= r_skid_cnt - 1'b1;
        default: r_skid_cnt <= r_skid_cnt;
      endcase

      if (w_start && (r_state == S_IDLE)) r_wr_cnt <= '0;
    end
  end

  // Data storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge usbdataclk) begin
    if (w_push) r_skid[r_wptr] <= usbdata;
  end

  assign usbdadd     = r_addr;
  assign fx2_fd      = r_fd;
  assign fx2_slwr_n  = r_slwr_n;
  assign fx2_fifoadr = EP_ADDR;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_usb_fifo_writer.sv
`timescale 1ns/1ps
// Bench for usb_fifo_writer: three instances (RD_LAT 1, 2, 3) share the
// stimulus; each has its own latency-matched buffer model. A transfer-level
// model checks every cycle: bytes appear in address order, no strobe while
// full, one pass over the addresses, busy/xfer_done/overrun timing.
module tb_usb_fifo_writer;
  localparam int NI = 3;
  localparam int BB = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic send_go = 1'b0;
  logic full_n = 1'b1;

  always #5 clk = ~clk;

  logic [10:0] o_addr    [NI];
  logic [7:0]  o_fd      [NI];
  logic        o_slwr_n  [NI];
  logic [1:0]  o_fifoadr [NI];
  logic        o_busy    [NI];
  logic        o_done    [NI];
  logic        o_ovr     [NI];
  logic [7:0]  ram       [BB];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [10:0] addr_pipe [g+1];
      logic [7:0]  rd_data;
      always @(posedge clk) begin
        addr_pipe[0] <= o_addr[g];
        for (int k = 1; k <= g; k++) addr_pipe[k] <= addr_pipe[k-1];
      end
      assign rd_data = ram[addr_pipe[g]];
      usb_fifo_writer #(.BLOCK_BYTES(BB), .ADDR_W(11), .RD_LAT(g+1),
                        .SKID_DEPTH(4), .EP_ADDR(2'b10)) u_dut (
        .usbdataclk (clk),
        .rst_n      (rst_n),
        .send_go    (send_go),
        .usbdata    (rd_data),
        .usbdadd    (o_addr[g]),
        .fx2_full_n (full_n),
        .fx2_fd     (o_fd[g]),
        .fx2_slwr_n (o_slwr_n[g]),
        .fx2_fifoadr(o_fifoadr[g]),
        .busy       (o_busy[g]),
        .xfer_done  (o_done[g]),
        .overrun    (o_ovr[g])
      );
    end
  endgenerate

  int n_chk = 0;
  int n_fail = 0;

  int m_wr [NI], m_pa [NI], m_c2047 [NI], m_xfers [NI];
  bit m_busy [NI], m_ovr [NI], m_due [NI], m_clr [NI], m_wrap [NI];
  int t_cyc [NI], t_first [NI], t_busy [NI], t_alast [NI];
  bit sg1, sg2, fp;

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_wr[i] = 0; m_pa[i] = 0; m_c2047[i] = 0; m_xfers[i] = 0;
      m_busy[i] = 0; m_ovr[i] = 0; m_due[i] = 0; m_clr[i] = 0; m_wrap[i] = 0;
      t_cyc[i] = 0; t_first[i] = -1; t_busy[i] = 0; t_alast[i] = -1;
    end
    sg1 = 0; sg2 = 0; fp = 1;
  end

  task automatic chk(input bit ok, input string nm, input int inst, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s inst%0d got %0d expected %0d at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs are sampled on the falling edge.
  always @(negedge clk) begin
    bit st;
    int a;
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_busy[i] = 0; m_ovr[i] = 0; m_due[i] = 0; m_clr[i] = 0;
        m_wr[i] = 0; m_pa[i] = 0; m_wrap[i] = 0; m_c2047[i] = 0;
      end
      sg1 = 0; sg2 = 0; fp = 1;
    end else begin
      st = sg1 & ~sg2;
      for (int i = 0; i < NI; i++) begin
        if (m_clr[i]) begin m_busy[i] = 0; m_clr[i] = 0; end
        if (st) begin
          if (m_busy[i]) m_ovr[i] = 1;
          else begin
            m_busy[i] = 1; m_wr[i] = 0; m_wrap[i] = 0; m_c2047[i] = 0;
            t_cyc[i] = 0; t_first[i] = -1; t_busy[i] = 0; t_alast[i] = -1;
          end
        end
        chk(o_busy[i] == m_busy[i], "busy", i, int'(o_busy[i]), int'(m_busy[i]));
        chk(o_ovr[i] == m_ovr[i], "overrun", i, int'(o_ovr[i]), int'(m_ovr[i]));
        chk(o_done[i] == m_due[i], "xfer_done", i, int'(o_done[i]), int'(m_due[i]));
        chk(o_fifoadr[i] == 2'b10, "fifoadr", i, int'(o_fifoadr[i]), 2);
        if (o_busy[i]) t_busy[i]++;
        if (m_due[i]) begin
          chk(m_c2047[i] == 1, "last_addr_once", i, m_c2047[i], 1);
          m_due[i] = 0; m_clr[i] = 1; m_xfers[i]++;
        end
        if (!o_slwr_n[i]) begin
          if (m_busy[i] && m_wr[i] < BB) begin
            chk(fp, "write_while_full", i, int'(fp), 1);
            chk(o_fd[i] == ram[m_wr[i]], "fd_data", i, int'(o_fd[i]), int'(ram[m_wr[i]]));
            if (t_first[i] < 0) t_first[i] = t_cyc[i];
            m_wr[i]++;
            if (m_wr[i] == BB) m_due[i] = 1;
          end else begin
            chk(1'b0, "extra_write", i, m_wr[i], BB);
          end
        end
        a = int'(o_addr[i]);
        if (!m_busy[i]) chk(a == 0, "addr_idle", i, a, 0);
        else if (m_wrap[i]) chk(a == 0, "addr_after_wrap", i, a, 0);
        else if (a != m_pa[i]) begin
          chk(a == m_pa[i] + 1 || (m_pa[i] == BB-1 && a == 0), "addr_step", i, a, m_pa[i] + 1);
          if (a == 0) m_wrap[i] = 1;
        end else if (a == BB-1) chk(1'b0, "addr_dwell_last", i, a, 0);
        if (a == BB-1) begin
          m_c2047[i]++;
          if (t_alast[i] < 0) t_alast[i] = t_cyc[i];
        end
        m_pa[i] = a;
        t_cyc[i]++;
      end
      fp = full_n; sg2 = sg1; sg1 = send_go;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_ram();
    for (int k = 0; k < BB; k++) ram[k] = 8'($urandom);
  endtask

  task automatic go(input int n);
    send_go = 1'b1; cyc(n); send_go = 1'b0;
  endtask

  task automatic wait_xfers(input int tgt, input string nm);
    int k;
    k = 0;
    while (k < 30000 && !(m_xfers[0] >= tgt && m_xfers[1] >= tgt && m_xfers[2] >= tgt)) begin
      cyc(1); k++;
    end
    chk(k < 30000, nm, 0, k, 30000);
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (k < 10000 && m_wr[1] < n) begin cyc(1); k++; end
    chk(k < 10000, "wait_bytes", 1, m_wr[1], n);
  endtask

  initial begin
    int xf;
    int k;
    xf = 0;
    fill_ram();
    cyc(3);
    for (int i = 0; i < NI; i++) begin
      chk(o_addr[i] == 0, "rst_addr", i, int'(o_addr[i]), 0);
      chk(o_fd[i] == 0, "rst_fd", i, int'(o_fd[i]), 0);
      chk(o_slwr_n[i] == 1, "rst_slwr", i, int'(o_slwr_n[i]), 1);
      chk(o_fifoadr[i] == 2'b10, "rst_fifoadr", i, int'(o_fifoadr[i]), 2);
      chk(o_busy[i] == 0, "rst_busy", i, int'(o_busy[i]), 0);
      chk(o_done[i] == 0, "rst_done", i, int'(o_done[i]), 0);
      chk(o_ovr[i] == 0, "rst_ovr", i, int'(o_ovr[i]), 0);
    end
    rst_n = 1'b1;
    cyc(5);

    // Single block, no back-pressure, send_go held 3 cycles.
    go(3); xf++;
    wait_xfers(xf, "t1_timeout");
    cyc(30);
    for (int i = 0; i < NI; i++) begin
      chk(m_xfers[i] == xf, "t1_single", i, m_xfers[i], xf);
      chk(m_wr[i] == BB, "t1_bytes", i, m_wr[i], BB);
      chk(t_first[i] == i + 3, "t1_first_strobe", i, t_first[i], i + 3);
    end
    for (int i = 0; i < 2; i++) begin
      chk(t_busy[i] == 2052 + i, "t1_busy_len", i, t_busy[i], 2052 + i);
      chk(t_alast[i] == 2047, "t1_sweep", i, t_alast[i], 2047);
    end

    // Back-pressure at bytes 100 and 511.
    fill_ram();
    go(1); xf++;
    wait_bytes(100);
    full_n = 1'b0; cyc(7); full_n = 1'b1;
    wait_bytes(511);
    full_n = 1'b0; cyc(1); full_n = 1'b1;
    wait_xfers(xf, "t2_timeout");
    cyc(10);
    for (int i = 0; i < NI; i++) chk(m_wr[i] == BB, "t2_bytes", i, m_wr[i], BB);

    // Full held for 1000 cycles from start.
    fill_ram();
    full_n = 1'b0;
    go(1); xf++;
    cyc(500);
    for (int i = 0; i < NI; i++) begin
      chk(o_addr[i] == 4, "t3_stall_addr", i, int'(o_addr[i]), 4);
      chk(m_wr[i] == 0, "t3_no_write", i, m_wr[i], 0);
    end
    cyc(499);
    full_n = 1'b1;
    wait_xfers(xf, "t3_timeout");
    cyc(10);
    for (int i = 0; i < NI; i++) chk(m_wr[i] == BB, "t3_bytes", i, m_wr[i], BB);

    // Overrun: second edge at byte 1000.
    fill_ram();
    go(2); xf++;
    wait_bytes(1000);
    go(2);
    wait_xfers(xf, "t4_timeout");
    cyc(50);
    for (int i = 0; i < NI; i++) begin
      chk(o_ovr[i] == 1, "t4_overrun_sticky", i, int'(o_ovr[i]), 1);
      chk(m_xfers[i] == xf, "t4_no_second", i, m_xfers[i], xf);
      chk(m_wr[i] == BB, "t4_bytes", i, m_wr[i], BB);
    end

    // Reset mid-transfer at byte 700.
    fill_ram();
    go(1);
    wait_bytes(700);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk(o_slwr_n[i] == 1, "t5_slwr", i, int'(o_slwr_n[i]), 1);
      chk(o_busy[i] == 0, "t5_busy", i, int'(o_busy[i]), 0);
      chk(o_addr[i] == 0, "t5_addr", i, int'(o_addr[i]), 0);
      chk(o_ovr[i] == 0, "t5_ovr", i, int'(o_ovr[i]), 0);
    end
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    for (int i = 0; i < NI; i++) chk(o_busy[i] == 0, "t5_no_restart", i, int'(o_busy[i]), 0);
    go(1); xf++;
    wait_xfers(xf, "t5_timeout");
    cyc(10);
    for (int i = 0; i < NI; i++) chk(m_wr[i] == BB, "t5_bytes", i, m_wr[i], BB);

    // Random back-pressure with stray send_go edges during the transfer.
    for (int r = 0; r < 2; r++) begin
      fill_ram();
      go($urandom_range(1, 4)); xf++;
      k = 0;
      while (k < 30000 && !(m_xfers[0] >= xf && m_xfers[1] >= xf && m_xfers[2] >= xf)) begin
        full_n = ($urandom_range(0, 3) != 0);
        send_go = (m_wr[0] > 10 && m_wr[0] < 1500) ? ($urandom_range(0, 199) == 0) : 1'b0;
        cyc(1); k++;
      end
      full_n = 1'b1; send_go = 1'b0;
      chk(k < 30000, "t6_timeout", 0, k, 30000);
      cyc(10);
      for (int i = 0; i < NI; i++) chk(m_wr[i] == BB, "t6_bytes", i, m_wr[i], BB);
    end

    cyc(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
